reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares one DWIDTH-bit register (reg_dut) between NREQ requesters.
- Each requester presents data with a valid/ready handshake.
- The arbiter selects one winner, drives the register input for the capture edge, then checks the register output against the written value.
- It sits between the requester agents and the reg_dut data_in/data_out pins, inside the register testbench wrapper level.

Parameters:
- DWIDTH, 32, data width of the shared register and of each requester payload.
- NREQ, 4, number of requesters (2..16); IDXW = $clog2(NREQ) is derived, not overridable.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NREQ  per-requester write request.
- req_data_i  in  NREQ*DWIDTH  flattened payloads; requester k occupies bits [k*DWIDTH +: DWIDTH].
- req_ready_o  out  NREQ  one-hot accept pulse.
- reg_data_o  out  DWIDTH  drives reg_dut data_in.
- reg_q_i  in  DWIDTH  from reg_dut data_out.
- grant_idx_o  out  IDXW  index of the last granted requester.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when a write has been checked.
- err_o  out  1  sticky readback mismatch flag.
- clr_err_i  in  1  synchronous clear of err_o.

Behaviour:
- Reset (rst_i low, async), all registered outputs and state:
  - state=IDLE, reg_data_o=0, req_ready_o=0, grant_idx_o=0, busy_o=0, done_o=0, err_o=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- Reset mid-operation aborts the write. No ready or done is issued for it.
- All outputs are registered. No combinational input-to-output path.
- FSM states: IDLE, CAPT, CHECK. Fixed sequence IDLE -> CAPT -> CHECK -> IDLE. One write per 3 cycles at most.
- IDLE, if any req_valid_i is high at edge E0:
  - Winner = first valid index scanning last+1, last+2, ... modulo NREQ.
  - At E0 register: reg_data_o <= winner data, grant_idx_o <= winner, last <= winner, req_ready_o <= one-hot(winner), state <= CAPT.
  - If no valid is high, stay in IDLE and hold reg_data_o.
- CAPT (cycle after E0):
  - req_ready_o[winner] is high for exactly this cycle. The handshake completes at edge E1.
  - reg_dut captures reg_data_o at E1.
  - At E1: req_ready_o <= 0, state <= CHECK.
- CHECK:
  - At edge E2, compare reg_q_i with reg_data_o.
  - done_o <= 1 for one cycle, err_o <= err_o | mismatch, state <= IDLE.
- Requester obligations:
  - Hold valid and data stable until ready is seen.
  - Valid still high in the cycle after ready counts as a new request.
- Requester drops valid during CAPT: the write still completes with the data latched at E0, ready still pulses.
- reg_data_o holds the last written value indefinitely. reg_dut recaptures the same value every edge, which is harmless.
- Arbitration fairness: with all NREQ requesters continuously valid, the grant order is 0,1,..,NREQ-1,0,... No requester waits more than NREQ grants.
- Error clear: clr_err_i clears err_o at the next edge. If a mismatch is detected on the same edge, set wins.
- Invariants:
  - busy_o = (state != IDLE).
  - done_o is never high in the same cycle as any req_ready_o bit.
  - req_ready_o is always zero or one-hot.

Test Plan:
- Reset with all inputs idle -> reg_data_o=0, busy_o=0, err_o=0. Assert rst_i low asynchronously in CAPT -> outputs return to reset values immediately and no done_o pulse follows.
- Single request: req 2 valid with data 0xDEADBEEF -> req_ready_o=4'b0100 for one cycle 1 cycle after valid is sampled; reg_data_o=0xDEADBEEF; done_o pulse 2 cycles after ready; err_o=0; grant_idx_o=2.
- All four requesters valid continuously, data 0x11111111·k -> grants in order 0,1,2,3,0. Each ready is one cycle wide and 3 cycles apart. The final register value matches the last grantee.
- Contention after a grant: req 1 granted, then reqs 0 and 1 both valid -> req 0 wins the next grant (pointer moves past 1); req 1 wins the one after.
- Readback fault: force reg_q_i=0x00000000 after writing 0xA5A5A5A5 -> err_o=1 after the done_o pulse and stays 1 across later good writes. clr_err_i pulse -> err_o=0 on the next cycle.
- Valid dropped during CAPT: req 3 writes 0x12345678 and deasserts valid in the ready cycle -> write completes, done_o pulses, err_o=0, arbiter returns to IDLE with no extra grant.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for one shared DWIDTH-bit register.
// Each accepted write takes three cycles: grant (IDLE), capture (CAPT), readback (CHECK).
// Every output comes straight from a flop, so no input reaches an output combinationally.
module reg_write_arbiter #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NREQ   = 4,
  localparam int unsigned IDXW  = $clog2(NREQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ*DWIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic [DWIDTH-1:0]      reg_data_o,
  input  logic [DWIDTH-1:0]      reg_q_i,
  output logic [IDXW-1:0]        grant_idx_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  input  logic                   clr_err_i
);

  typedef enum logic [1:0] {StIdle, StCapt, StCheck} state_e;

  localparam logic [IDXW-1:0] LastInit = IDXW'(NREQ - 1);
  localparam logic [NREQ-1:0] OneLsb   = {{(NREQ-1){1'b0}}, 1'b1};

  state_e              r_state, w_state_next;
  logic [IDXW-1:0]     r_last, w_last_next;
  logic [IDXW-1:0]     r_grant, w_grant_next;
  logic [NREQ-1:0]     r_ready, w_ready_next;
  logic [DWIDTH-1:0]   r_data, w_data_next;
  logic                r_busy, r_done, w_done_next, r_err, w_err_next;

  logic                w_found;
  logic [IDXW-1:0]     w_winner;
  logic [31:0]         w_cand;
  logic [DWIDTH-1:0]   w_win_data;
  logic                w_mismatch;

  // Winner search: first valid requester after the last grantee, wrapping modulo NREQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = (32'(r_last) + k) % NREQ;
      if (!w_found && req_valid_i[w_cand[IDXW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[IDXW-1:0];
      end
    end
  end

  // Payload mux for the winning requester.
  always_comb begin
    w_win_data = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (int'(w_winner) == k) w_win_data = req_data_i[k*DWIDTH +: DWIDTH];
    end
  end

  assign w_mismatch = (reg_q_i != r_data);

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state logic: fixed IDLE -> CAPT -> CHECK -> IDLE sequence.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_found) w_state_next = StCapt;
      StCapt:  w_state_next = StCheck;
      StCheck: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    w_data_next  = r_data;
    w_grant_next = r_grant;
    w_last_next  = r_last;
    w_ready_next = '0;
    w_done_next  = 1'b0;
    w_err_next   = clr_err_i ? 1'b0 : r_err;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_data_next  = w_win_data;
          w_grant_next = w_winner;
          w_last_next  = w_winner;
          w_ready_next = OneLsb << w_winner;
        end
      end
      StCapt: ;
      StCheck: begin
        w_done_next = 1'b1;
        // A mismatch on the clearing edge still sets the flag.
        if (w_mismatch) w_err_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs and round-robin pointer; reset aborts any write in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_data  <= '0;
      r_grant <= '0;
      r_last  <= LastInit;
      r_ready <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_data  <= w_data_next;
      r_grant <= w_grant_next;
      r_last  <= w_last_next;
      r_ready <= w_ready_next;
      r_busy  <= (w_state_next != StIdle);
      r_done  <= w_done_next;
      r_err   <= w_err_next;
    end
  end

  assign reg_data_o  = r_data;
  assign grant_idx_o = r_grant;
  assign req_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural reg_dut and readback fault injection.
module tb_reg_write_arbiter;

  localparam int unsigned DWIDTH = 32;
  localparam int unsigned NREQ   = 4;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ*DWIDTH-1:0] req_data_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [DWIDTH-1:0]      reg_data_o;
  logic [DWIDTH-1:0]      reg_q_i;
  logic [1:0]             grant_idx_o;
  logic                   busy_o, done_o, err_o, clr_err_i;

  logic [DWIDTH-1:0]      dut_q = '0;
  logic                   fault = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Shared register model; fault forces a stuck-at-zero readback.
  always @(posedge clk) dut_q <= reg_data_o;
  assign reg_q_i = fault ? '0 : dut_q;

  reg_write_arbiter #(.DWIDTH(DWIDTH), .NREQ(NREQ)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .reg_data_o  (reg_data_o),
    .reg_q_i     (reg_q_i),
    .grant_idx_o (grant_idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .clr_err_i   (clr_err_i)
  );

  // Continuous invariants: ready zero or one-hot, never alongside done.
  always @(negedge clk) begin
    if (rst_i) begin
      checks++;
      if (((req_ready_o & (req_ready_o - 1'b1)) != '0) || (done_o && (req_ready_o != '0))) begin
        errors++;
        $display("FAIL invariant: ready=%b done=%b", req_ready_o, done_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; req_valid_i = '0; req_data_i = '0; clr_err_i = 1'b0;
    #2;
    checks++;
    if ({reg_data_o, req_ready_o, grant_idx_o, busy_o, done_o, err_o} !== '0) begin
      errors++;
      $display("FAIL reset_values: got data=%h ready=%b grant=%0d busy=%b done=%b err=%b want all 0",
               reg_data_o, req_ready_o, grant_idx_o, busy_o, done_o, err_o);
    end
    rst_i = 1'b1;
    tick();
    // Start a write, then reset asynchronously in CAPT.
    req_valid_i = 4'b0010;
    req_data_i[1*DWIDTH +: DWIDTH] = 32'hCAFEF00D;
    tick();
    checks++;
    if (busy_o !== 1'b1 || req_ready_o !== 4'b0010) begin
      errors++;
      $display("FAIL abort_setup: got busy=%b ready=%b want 1 0010", busy_o, req_ready_o);
    end
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({reg_data_o, req_ready_o, grant_idx_o, busy_o, done_o} !== '0) begin
      errors++;
      $display("FAIL async_abort: got data=%h ready=%b grant=%0d busy=%b want 0",
               reg_data_o, req_ready_o, grant_idx_o, busy_o);
    end
    req_valid_i = '0;
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done: cycle %0d got done=%b busy=%b want 0 0", i, done_o, busy_o);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_order [5];
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 4; k++) req_data_i[k*DWIDTH +: DWIDTH] = 32'h11111111 * k;
    req_valid_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      checks++;
      if (req_ready_o !== (4'b0001 << exp_order[g]) || grant_idx_o !== exp_order[g] ||
          reg_data_o !== 32'h11111111 * exp_order[g]) begin
        errors++;
        $display("FAIL rr_grant%0d: got ready=%b grant=%0d data=%h want idx %0d", g,
                 req_ready_o, grant_idx_o, reg_data_o, exp_order[g]);
      end
      tick();
      checks++;
      if (req_ready_o !== 4'b0000) begin
        errors++;
        $display("FAIL rr_ready_width%0d: got %b want 0000", g, req_ready_o);
      end
      tick();
      checks++;
      if (done_o !== 1'b1) begin
        errors++;
        $display("FAIL rr_done%0d: got %b want 1", g, done_o);
      end
    end
    req_valid_i = '0;
    tick();
    checks++;
    if (reg_data_o !== 32'h0 || grant_idx_o !== 2'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rr_final: got data=%h grant=%0d busy=%b want 0 0 0",
               reg_data_o, grant_idx_o, busy_o);
    end
  endtask

  task automatic test_single();
    req_valid_i = 4'b0100;
    req_data_i[2*DWIDTH +: DWIDTH] = 32'hDEADBEEF;
    tick();
    checks++;
    if (req_ready_o !== 4'b0100 || reg_data_o !== 32'hDEADBEEF || grant_idx_o !== 2'd2 ||
        busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got ready=%b data=%h grant=%0d busy=%b want 0100 deadbeef 2 1",
               req_ready_o, reg_data_o, grant_idx_o, busy_o);
    end
    req_valid_i = '0;
    tick();
    checks++;
    if (req_ready_o !== 4'b0000 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL single_capt_exit: got ready=%b done=%b want 0000 0", req_ready_o, done_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got done=%b err=%b busy=%b want 1 0 0", done_o, err_o, busy_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || req_ready_o !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle: got done=%b ready=%b want 0 0000", done_o, req_ready_o);
    end
  endtask

  task automatic test_contention();
    // Pointer is at 2: requester 1 alone wins, then 0 beats 1, then 1 again.
    req_data_i[0*DWIDTH +: DWIDTH] = 32'h00000A0A;
    req_data_i[1*DWIDTH +: DWIDTH] = 32'h00000B0B;
    req_valid_i = 4'b0010;
    tick();
    checks++;
    if (req_ready_o !== 4'b0010 || grant_idx_o !== 2'd1) begin
      errors++;
      $display("FAIL cont_first: got ready=%b grant=%0d want 0010 1", req_ready_o, grant_idx_o);
    end
    req_valid_i = 4'b0011;
    tick(); tick(); tick();
    checks++;
    if (req_ready_o !== 4'b0001 || grant_idx_o !== 2'd0 || reg_data_o !== 32'h00000A0A) begin
      errors++;
      $display("FAIL cont_second: got ready=%b grant=%0d data=%h want 0001 0 00000a0a",
               req_ready_o, grant_idx_o, reg_data_o);
    end
    req_valid_i = 4'b0010;
    tick(); tick(); tick();
    checks++;
    if (req_ready_o !== 4'b0010 || grant_idx_o !== 2'd1 || reg_data_o !== 32'h00000B0B) begin
      errors++;
      $display("FAIL cont_third: got ready=%b grant=%0d data=%h want 0010 1 00000b0b",
               req_ready_o, grant_idx_o, reg_data_o);
    end
    req_valid_i = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_readback_fault();
    // Pointer at 1: requester 2 wins, readback forced to zero.
    req_valid_i = 4'b0100;
    req_data_i[2*DWIDTH +: DWIDTH] = 32'hA5A5A5A5;
    tick();
    req_valid_i = '0;
    fault = 1'b1;
    tick(); tick();
    checks++;
    if (done_o !== 1'b1 || err_o !== 1'b1) begin
      errors++;
      $display("FAIL fault_detect: got done=%b err=%b want 1 1", done_o, err_o);
    end
    fault = 1'b0;
    // Good write from requester 3 must leave the flag set.
    req_valid_i = 4'b1000;
    req_data_i[3*DWIDTH +: DWIDTH] = 32'h0F0F0F0F;
    tick();
    req_valid_i = '0;
    tick(); tick();
    checks++;
    if (done_o !== 1'b1 || err_o !== 1'b1) begin
      errors++;
      $display("FAIL fault_sticky: got done=%b err=%b want 1 1", done_o, err_o);
    end
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: got err=%b want 0", err_o);
    end
    // Clear asserted on the same edge as a new mismatch: set wins.
    req_valid_i = 4'b0001;
    req_data_i[0*DWIDTH +: DWIDTH] = 32'h5A5A5A5A;
    tick();
    req_valid_i = '0;
    fault = 1'b1;
    tick();
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    fault = 1'b0;
    checks++;
    if (done_o !== 1'b1 || err_o !== 1'b1) begin
      errors++;
      $display("FAIL fault_set_wins: got done=%b err=%b want 1 1", done_o, err_o);
    end
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
  endtask

  task automatic test_valid_drop();
    // Pointer at 0: requester 3 is the only valid one.
    req_valid_i = 4'b1000;
    req_data_i[3*DWIDTH +: DWIDTH] = 32'h12345678;
    tick();
    checks++;
    if (req_ready_o !== 4'b1000 || reg_data_o !== 32'h12345678) begin
      errors++;
      $display("FAIL drop_grant: got ready=%b data=%h want 1000 12345678", req_ready_o, reg_data_o);
    end
    req_valid_i = '0;
    tick(); tick();
    checks++;
    if (done_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_done: got done=%b err=%b want 1 0", done_o, err_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (req_ready_o !== 4'b0000 || busy_o !== 1'b0 || grant_idx_o !== 2'd3 ||
          reg_data_o !== 32'h12345678) begin
        errors++;
        $display("FAIL drop_idle%0d: got ready=%b busy=%b grant=%0d data=%h want 0000 0 3 12345678",
                 i, req_ready_o, busy_o, grant_idx_o, reg_data_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_contention();
    test_readback_fault();
    test_valid_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
